// File: rtl/apb_master_if.sv
// apb_master_if: command/response handshake and APB4 bus bundle for the APB initiator
interface apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-beat command to APB4 transfer initiator; optional ACCESS timeout via APB_MASTER_TIMEOUT_EN
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        pclk_i,
    input  logic        prst_i,
    apb_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state_q, state_d;
    logic        accept, done, tmo;
    logic [11:0] paddr_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [3:0]  pstrb_q;
    logic        rsp_valid_q, rsp_slverr_q, rsp_timeout_q;
    logic [31:0] rsp_rdata_q;

    assign bus.cmd_ready = (state_q == IDLE) && !prst_i;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign done          = (state_q == ACCESS) && bus.pready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    assign tmo = (state_q == ACCESS) && !bus.pready && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    // Count stalled ACCESS cycles; restart every time a transfer enters ACCESS
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) cnt_q <= '0;
        else cnt_q <= (state_q == SETUP) ? '0 : (state_q == ACCESS && !bus.pready) ? cnt_q + 1'b1 : cnt_q;
    end
`else
    assign tmo = 1'b0;
`endif

    // Transfer phase sequencing; pready only matters in ACCESS
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (done || tmo) ? IDLE : ACCESS;
            default: state_d = IDLE;
        endcase
    end

    // State and captured command; APB fields hold their last value while idle
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                paddr_q  <= bus.cmd_addr;
                pwrite_q <= bus.cmd_write;
                pwdata_q <= bus.cmd_wdata;
                pstrb_q  <= bus.cmd_write ? bus.cmd_strb : 4'b0000;
            end
        end
    end

    // One-cycle registered response for each completed or aborted transfer
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= done || tmo;
            rsp_rdata_q   <= (done && !pwrite_q) ? bus.prdata : '0;
            rsp_slverr_q  <= done ? bus.pslverr : tmo;
            rsp_timeout_q <= tmo;
        end
    end

    assign bus.psel        = state_q != IDLE;
    assign bus.penable     = state_q == ACCESS;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench with a word-memory APB slave and reference model
module tb_apb_master;
    localparam int TO = 16;

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [31:0] rd;
        logic        err;
        logic        tmo;
        int          due;
    } exp_t;

    typedef struct {
        int   waits;
        logic err;
    } slv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_master_if bus();
    apb_master #(.TIMEOUT_CYCLES(TO)) dut (.pclk_i(clk), .prst_i(rst), .bus(bus));

    exp_t        sb[$];
    slv_t        sq[$];
    logic [31:0] mem_m[16];
    logic [31:0] mem_s[16];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    slv_t        cur;
    int          wcnt;
    exp_t        me;
    logic [49:0] saved;
    logic        prev_psel;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Slave: random noise outside ACCESS, programmed wait states and error inside it
    initial begin
        bus.pready = 1'b0;
        bus.prdata = '0;
        bus.pslverr = 1'b0;
        cur = '{0, 1'b0};
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.psel && !bus.penable) begin
                cur = (sq.size() != 0) ? sq.pop_front() : '{0, 1'b0};
                wcnt = 0;
                bus.pready = 1'($urandom_range(0, 1));
                bus.prdata = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end else if (bus.psel && bus.penable) begin
                if (wcnt == cur.waits) begin
                    bus.pready = 1'b1;
                    bus.pslverr = cur.err;
                    bus.prdata = bus.pwrite ? $urandom : mem_s[bus.paddr[5:2]];
                    if (bus.pwrite && !cur.err) mem_s[bus.paddr[5:2]] = merge(mem_s[bus.paddr[5:2]], bus.pwdata, bus.pstrb);
                end else begin
                    bus.pready = 1'b0;
                    bus.prdata = $urandom;
                    bus.pslverr = 1'($urandom_range(0, 1));
                end
                wcnt++;
            end else begin
                bus.pready = 1'($urandom_range(0, 1));
                bus.prdata = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: APB phase/stability checks and scoreboard compare on every response
    initial begin
        prev_psel = 1'b0;
        saved = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.psel && !bus.penable) begin
                    if (sb.size() == 0) chk("setup_unexpected", 1, 0);
                    else begin
                        chk("setup_addr", bus.paddr, sb[0].a);
                        chk("setup_write", bus.pwrite, sb[0].w);
                        chk("setup_wdata", bus.pwdata, sb[0].wd);
                        chk("setup_strb", bus.pstrb, sb[0].w ? sb[0].st : 4'h0);
                    end
                    saved = {bus.psel, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb};
                end
                if (bus.penable) begin
                    chk("access_after_setup", prev_psel, 1);
                    chk("access_stable", {bus.psel, bus.paddr, bus.pwrite, bus.pwdata, bus.pstrb}, saved);
                end
                if (bus.rsp_valid) begin
                    if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
                    else begin
                        me = sb.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, me.rd);
                        chk("rsp_slverr", bus.rsp_slverr, me.err);
                        chk("rsp_timeout", bus.rsp_timeout, me.tmo);
                        chk("rsp_latency", cyc, me.due);
                        chk("rsp_cmd_ready", bus.cmd_ready, 1);
                    end
                end
                prev_psel = bus.psel;
            end
        end
    end

    // Present one command (from a negedge) and record its expected outcome when accepted
    task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int waits, input logic err);
        exp_t e;
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr = a;
        bus.cmd_wdata = wd;
        bus.cmd_strb = st;
        while (!bus.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_bound", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        e.w = w;
        e.a = a;
        e.wd = wd;
        e.st = st;
        e.rd = w ? 32'h0 : mem_m[a[5:2]];
        e.err = err;
        e.tmo = 1'b0;
        e.due = cyc + 3 + waits;
`ifdef APB_MASTER_TIMEOUT_EN
        if (waits >= TO) begin
            e.rd = 32'h0;
            e.err = 1'b1;
            e.tmo = 1'b1;
            e.due = cyc + 2 + TO;
        end
`endif
        if (w && !e.err) mem_m[a[5:2]] = merge(mem_m[a[5:2]], wd, st);
        sb.push_back(e);
        sq.push_back('{waits, err});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr = 12'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_strb = 4'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(0);
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = '0;
            mem_s[i] = '0;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 0);
        chk("reset_bus", {bus.paddr, bus.pwdata, bus.pstrb}, 0);
        chk("reset_rdata", bus.rsp_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b1, 12'h000, 32'h0000_0302, 4'b0011, 1, 1'b0);
        idle(2);
        issue(1'b1, 12'h004, 32'hDEAD_BEEF, 4'b1111, 0, 1'b0);
        idle(1);
        issue(1'b0, 12'h004, 32'h0, 4'b1111, 0, 1'b0);
        idle(1);
        issue(1'b1, 12'h008, 32'h1234_5678, 4'b1111, 0, 1'b1);
        issue(1'b0, 12'h008, 32'h0, 4'b0000, 2, 1'b0);
        issue(1'b0, 12'h000, 32'h0, 4'b0000, 0, 1'b0);
        idle(1);
        issue(1'b0, 12'h010, 32'h0, 4'b0000, TO + 4, 1'b0);
        drain();
        issue(1'b0, 12'h00C, 32'h0, 4'b0000, 5, 1'b0);
        idle(0);
        for (int n = 0; n < 10 && !bus.penable; n++) @(negedge clk);
        chk("rst_test_in_access", bus.penable, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid}, 0);
        chk("rst_mid_bus", {bus.paddr, bus.pwdata, bus.pstrb}, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", bus.cmd_ready, 1);
        issue(1'b1, 12'h00C, 32'hCAFE_F00D, 4'b0101, 0, 1'b0);
        issue(1'b0, 12'h00C, 32'h0, 4'b0000, 1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            issue(1'($urandom_range(0, 1)), 12'($urandom) & 12'hFFC, $urandom, 4'($urandom),
                  $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        drain();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
